// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RV32I five-stage hazard unit with forwarding, load-use stall,
// branch flush, memory-wait freeze with timeout error, and perf counters.
`default_nettype none

module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [7:0]       TIMEOUT  = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       mem_stall;
  logic       lw_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic wm, input logic [4:0] rdm,
                                         input logic ww, input logic [4:0] rdw);
    if (wm && rdm != 5'd0 && rdm == rs)      return 2'b10;
    else if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
    else                                     return 2'b00;
  endfunction

  assign mem_stall = (state == RUN || state == MEM_WAIT) && MemReqM && !MemReadyM;
  // A taken branch squashes the dependent instruction, so no load-use stall is needed.
  assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;
  assign MemErr    = (state == ERROR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          state_nxt = RUN;
          wait_nxt  = 8'd0;
        end else if (wait_cnt == TIMEOUT) begin
          state_nxt = ERROR;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (!reset) begin
      ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
      ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
      // Whole-pipe freeze holds a pending branch in E until the access completes.
      if (state == ERROR || mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE;
        FlushE = lw_stall | PCSrcE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && StallCount != CNT_MAX) StallCount <= StallCount + CNT_W'(1);
      if (FlushD && FlushCount != CNT_MAX) FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire
